// File: rtl/image_capture.sv
// Frame-buffer sink for a raster-order pixel stream, with column/row/pixel tracking,
// done/overrun flags and a registered readback port. Define CAPTURE_CHECKSUM_EN to add a 16-bit pixel sum.
//
// state     | meaning
// S_IDLE    | waiting for start_capture; incoming pixels ignored
// S_CAPTURE | writing each valid pixel to mem[pixel_count]
// S_DONE    | full frame stored; further valid pixels set overrun
module image_capture #(
   parameter int IMAGE_WIDTH  = 110,
   parameter int IMAGE_HEIGHT = 103,
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 14
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_capture,
   input  logic [DATA_WIDTH-1:0] pixel_in,
   input  logic                  valid_in,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  overrun,
   output logic [ADDR_WIDTH-1:0] pixel_count,
   output logic [6:0]            col_out,
   output logic [6:0]            row_out,
   output logic [15:0]           checksum
);

   localparam int IMG_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;

   typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

   state_t                state_q, state_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  ovr_q, ovr_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic [6:0]            col_q, col_d;
   logic [6:0]            row_q, row_d;
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic                  we;

   logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

   always_comb begin
      state_d = state_q;
      ovr_d   = ovr_q;
      cnt_d   = cnt_q;
      col_d   = col_q;
      row_d   = row_q;
      we      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start_capture) begin
               state_d = S_CAPTURE;
               cnt_d   = '0;
               col_d   = '0;
               row_d   = '0;
            end
         end
         S_CAPTURE: begin
            // start_capture aborts the frame and wins over a same-cycle pixel
            if (start_capture) begin
               cnt_d = '0;
               col_d = '0;
               row_d = '0;
            end else if (valid_in) begin
               we    = 1'b1;
               cnt_d = cnt_q + 1'b1;
               if (col_q == 7'(IMAGE_WIDTH - 1)) begin
                  col_d = '0;
                  row_d = row_q + 1'b1;
               end else begin
                  col_d = col_q + 1'b1;
               end
               if (cnt_q == ADDR_WIDTH'(IMG_SIZE - 1)) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (start_capture) begin
               state_d = S_CAPTURE;
               ovr_d   = 1'b0;
               cnt_d   = '0;
               col_d   = '0;
               row_d   = '0;
            end else if (valid_in) begin
               ovr_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d == S_CAPTURE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovr_q   <= 1'b0;
         cnt_q   <= '0;
         col_q   <= '0;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ovr_q   <= ovr_d;
         cnt_q   <= cnt_d;
         col_q   <= col_d;
         row_q   <= row_d;
      end
   end

   // Frame buffer is never cleared; read-before-write gives old data on a same-address collision
   always_ff @(posedge clk) begin
      if (we && !reset) begin
         mem[cnt_q] <= pixel_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= mem[rd_addr];
      end
   end

`ifdef CAPTURE_CHECKSUM_EN
   logic [15:0] sum_q, sum_d;

   always_comb begin
      sum_d = sum_q;
      if (start_capture) begin
         sum_d = '0;
      end else if (we) begin
         sum_d = sum_q + 16'(pixel_in);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign checksum = sum_q;
`else
   assign checksum = 16'h0000;
`endif

   assign rd_data     = rd_data_q;
   assign busy        = busy_q;
   assign frame_done  = done_q;
   assign overrun     = ovr_q;
   assign pixel_count = cnt_q;
   assign col_out     = col_q;
   assign row_out     = row_q;

endmodule

// File: doc/image_capture.md
Name: image_capture

Overview:
- Sink-side counterpart of the pixel stream source: accepts the raster-order 8-bit pixel stream (pixel/valid) produced after filtering and writes it into an on-chip frame buffer.
- Tracks column/row and pixel count, and flags frame completion and overrun.
- Exposes a registered read port so a readback/UART/compare stage can drain the captured frame.

Parameters:
- IMAGE_WIDTH, 110, pixels per row.
- IMAGE_HEIGHT, 103, rows per frame.
- DATA_WIDTH, 8, pixel width.
- ADDR_WIDTH, 14, frame buffer address width; must satisfy 2^ADDR_WIDTH >= IMAGE_WIDTH*IMAGE_HEIGHT.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start_capture  in  1  single-cycle pulse; arms or restarts a capture at address 0.
- pixel_in  in  DATA_WIDTH  incoming pixel.
- valid_in  in  1  pixel_in is valid this cycle.
- rd_addr  in  ADDR_WIDTH  readback address.
- rd_data  out  DATA_WIDTH  readback data, registered.
- busy  out  1  high while in CAPTURE.
- frame_done  out  1  high while in DONE.
- overrun  out  1  sticky flag: valid_in was seen while in DONE.
- pixel_count  out  ADDR_WIDTH  pixels accepted in the current frame.
- col_out  out  7  current write column.
- row_out  out  7  current write row.
- checksum  out  16  frame checksum; see Optional Feature.

Behaviour:
- IMG_SIZE = IMAGE_WIDTH*IMAGE_HEIGHT (11330 by default). Internal write address equals pixel_count.
- Reset values: state IDLE; busy=0, frame_done=0, overrun=0; pixel_count=0, col_out=0, row_out=0; checksum=0; rd_data=0. Frame buffer contents are not cleared.
- FSM states: IDLE, CAPTURE, DONE.
- IDLE:
  - valid_in is ignored; no write.
  - start_capture: go to CAPTURE and clear counters. A pixel valid in the same cycle as start_capture is discarded.
- CAPTURE:
  - Each cycle with valid_in=1: write pixel_in to mem[pixel_count], then increment pixel_count.
  - col_out increments; when col_out=IMAGE_WIDTH-1 it wraps to 0 and row_out increments.
  - Gaps (valid_in=0) hold all counters.
  - Accepting the pixel at pixel_count=IMG_SIZE-1: write it, go to DONE. After that edge: frame_done=1, busy=0, pixel_count=IMG_SIZE, col_out=0, row_out=IMAGE_HEIGHT.
  - start_capture while in CAPTURE aborts the frame: counters cleared to 0, state stays CAPTURE. start_capture has priority over valid_in; that cycle's pixel is not written.
- DONE:
  - valid_in: no write, overrun<=1 (sticky).
  - start_capture: clear counters, frame_done and overrun; go to CAPTURE.
- Read port:
  - rd_data <= mem[rd_addr] every cycle in any state: 1-cycle latency.
  - Read and write to the same address in the same cycle returns the old data.
  - rd_addr >= IMG_SIZE returns undefined data; the bench does not check it.
- Reset mid-capture returns to IDLE with counters zeroed. Partially written data stays in memory.
- Arithmetic: all counters are unsigned and never exceed IMG_SIZE. Checksum is a modulo-2^16 wrap-around sum.

Optional Feature:
- Macro: CAPTURE_CHECKSUM_EN.
- Defined:
  - checksum accumulates the zero-extended pixel_in on every written pixel, modulo 2^16.
  - Cleared by reset and by every start_capture.
  - Holds its final value in DONE.
- Undefined: checksum is tied to 16'h0000 and no accumulator logic is synthesised.

Test Plan:
- Reset, pulse start_capture, stream 11330 pixels with pixel=addr[7:0] and valid_in continuous -> frame_done rises the cycle after the last accepted pixel; pixel_count=11330; overrun=0; readback of addresses 0, 109, 110 and 11329 returns 0x00, 0x6D, 0x6E and 0x41, each with 1-cycle latency.
- Same stream with valid_in toggling 1,0,0,1,... -> identical memory contents and completion. After 110 accepted pixels: col_out=0, row_out=1.
- After DONE, drive 3 valid pixels -> overrun=1, mem[0] unchanged. Then pulse start_capture -> overrun=0, frame_done=0, busy=1, pixel_count=0.
- Mid-frame: at pixel_count=500, pulse start_capture with valid_in=1 and pixel=0xAA -> pixel_count=0 and 0xAA is not written. The next valid pixel 0x55 lands at address 0.
- Reset asserted at pixel_count=1000 -> IDLE, all outputs 0. valid_in in IDLE causes no write and no count.
- With CAPTURE_CHECKSUM_EN defined, run the first test's stream -> checksum=16'hF261 in DONE. Without the macro, checksum=0 throughout.
